// File: rtl/parking_slot_allocator.sv
// -----------------------------------------------------------------------------
// parking_slot_allocator
//
// Entry-gate slot allocator for the parking system. When a car waits at the
// entry gate, this block reserves the lowest-index free slot, opens the gate,
// and holds the reservation until that slot's sensor reports the car parked or
// a timeout after the gate pass expires. It also publishes a registered
// free-slot count and a lot-full flag for the entry display.
//
// Parameters
//   NUM_SLOTS       number of slot sensors (1..15)
//   TIMEOUT_CYCLES  cycles after gate pass before the reservation drops (>=2)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cars         in   slot sensors, 1 = occupied; asynchronous to clk
//   entry_req    in   car waiting at the entry gate (level)
//   entry_ack    in   gate-pass sensor pulse
//   grant_valid  out  a slot is reserved for the current entry car
//   grant_slot   out  index of the reserved slot (valid with grant_valid)
//   gate_open    out  gate actuator drive
//   lot_full     out  no slot is both unoccupied and unreserved
//   free_count   out  number of unoccupied, unreserved slots
// -----------------------------------------------------------------------------
module parking_slot_allocator #(
    parameter int NUM_SLOTS      = 15,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SLOTS-1:0] cars,
    input  logic                 entry_req,
    input  logic                 entry_ack,
    output logic                 grant_valid,
    output logic [3:0]           grant_slot,
    output logic                 gate_open,
    output logic                 lot_full,
    output logic [3:0]           free_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_PARK  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_SLOTS-1:0]   cars_meta_q, cars_s_q;
    logic [NUM_SLOTS-1:0]   reserved_q, reserved_d;
    logic [3:0]             grant_slot_q, grant_slot_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [3:0]             free_count_q;
    logic                   lot_full_q;

    logic [NUM_SLOTS-1:0]   avail;
    logic [NUM_SLOTS-1:0]   pick_onehot;
    logic [3:0]             pick_idx;
    logic [3:0]             avail_cnt;
    logic                   slot_taken;

    // Two-flop synchroniser for the asynchronous slot sensors.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cars_meta_q <= '0;
            cars_s_q    <= '0;
        end else begin
            cars_meta_q <= cars;
            cars_s_q    <= cars_meta_q;
        end
    end

    // A reserved slot that is also occupied is excluded once, so the count
    // can never underflow.
    assign avail = ~cars_s_q & ~reserved_q;

    // Lowest-index free slot (downward scan so the lowest set bit wins) and
    // population count of available slots.
    // NOTE: every combinational output gets a default before any branch;
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        pick_idx    = '0;
        pick_onehot = '0;
        avail_cnt   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (avail[i]) begin
                pick_idx = 4'(i);
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            pick_onehot[i] = avail[i] && (pick_idx == 4'(i));
            avail_cnt      = avail_cnt + 4'(avail[i]);
        end
    end

    // reserved_q is one-hot while a grant is outstanding, so this is the
    // sensor of the granted slot.
    assign slot_taken = |(cars_s_q & reserved_q);

    always_comb begin
        state_d      = state_q;
        reserved_d   = reserved_q;
        grant_slot_d = grant_slot_q;
        timer_d      = timer_q;
        unique case (state_q)
            S_IDLE: begin
                if (entry_req && (avail != '0)) begin
                    state_d      = S_GRANT;
                    reserved_d   = pick_onehot;
                    grant_slot_d = pick_idx;
                end
            end
            S_GRANT: begin
                // Gate pass wins over a car reversing away or the slot being
                // taken by someone else in the same cycle.
                if (entry_ack) begin
                    state_d = S_PARK;
                    timer_d = TIMER_LOAD;
                end else if (!entry_req || slot_taken) begin
                    state_d    = S_IDLE;
                    reserved_d = '0;
                end
            end
            S_PARK: begin
                if (slot_taken || (timer_q == '0)) begin
                    state_d    = S_IDLE;
                    reserved_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                reserved_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            reserved_q   <= '0;
            grant_slot_q <= '0;
            timer_q      <= '0;
            free_count_q <= '0;
            lot_full_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            reserved_q   <= reserved_d;
            grant_slot_q <= grant_slot_d;
            timer_q      <= timer_d;
            free_count_q <= avail_cnt;
            lot_full_q   <= (avail == '0);
        end
    end

    // Decoded straight from the state register: glitch-free, and cleared
    // asynchronously together with the state on reset.
    assign grant_valid = (state_q == S_GRANT) || (state_q == S_PARK);
    assign gate_open   = (state_q == S_GRANT);
    assign grant_slot  = grant_slot_q;
    assign free_count  = free_count_q;
    assign lot_full    = lot_full_q;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// -----------------------------------------------------------------------------
// tb_parking_slot_allocator
//
// Directed bench for parking_slot_allocator. Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point, so a value driven in
// one step is first seen by the DUT at the next rising edge.
// -----------------------------------------------------------------------------
module tb_parking_slot_allocator;

    localparam int NUM_SLOTS = 15;
    localparam int TIMEOUT   = 20;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_SLOTS-1:0] cars;
    logic                 entry_req;
    logic                 entry_ack;
    logic                 grant_valid;
    logic [3:0]           grant_slot;
    logic                 gate_open;
    logic                 lot_full;
    logic [3:0]           free_count;

    int vectors = 0;
    int errors  = 0;

    parking_slot_allocator #(
        .NUM_SLOTS      (NUM_SLOTS),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cars        (cars),
        .entry_req   (entry_req),
        .entry_ack   (entry_ack),
        .grant_valid (grant_valid),
        .grant_slot  (grant_slot),
        .gate_open   (gate_open),
        .lot_full    (lot_full),
        .free_count  (free_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cars = '0; entry_req = 1'b0; entry_ack = 1'b0;
        #3;
        vectors++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rst_grant_valid got=%0b exp=0", grant_valid); end
        vectors++; if (gate_open !== 1'b0) begin errors++; $display("FAIL rst_gate_open got=%0b exp=0", gate_open); end
        vectors++; if (grant_slot !== 4'd0) begin errors++; $display("FAIL rst_grant_slot got=%0d exp=0", grant_slot); end
        vectors++; if (free_count !== 4'd0) begin errors++; $display("FAIL rst_free_count got=%0d exp=0", free_count); end
        vectors++; if (lot_full !== 1'b0) begin errors++; $display("FAIL rst_lot_full got=%0b exp=0", lot_full); end
        step(2);
        rst_n = 1'b1;
        step(1);
        vectors++; if (free_count !== 4'd15) begin errors++; $display("FAIL rst_free_after got=%0d exp=15", free_count); end
    endtask

    // Empty lot: slot 0 granted, count drops one cycle after the grant.
    task automatic test_first_grant();
        entry_req = 1'b1;
        step(1);
        vectors++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL t1_grant_valid got=%0b exp=1", grant_valid); end
        vectors++; if (gate_open !== 1'b1) begin errors++; $display("FAIL t1_gate_open got=%0b exp=1", gate_open); end
        vectors++; if (grant_slot !== 4'd0) begin errors++; $display("FAIL t1_grant_slot got=%0d exp=0", grant_slot); end
        vectors++; if (free_count !== 4'd15) begin errors++; $display("FAIL t1_free_pre got=%0d exp=15", free_count); end
        step(1);
        vectors++; if (free_count !== 4'd14) begin errors++; $display("FAIL t1_free_post got=%0d exp=14", free_count); end
        // Car reverses away: reservation released.
        entry_req = 1'b0;
        step(1);
        vectors++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL t1_release got=%0b exp=0", grant_valid); end
        step(1);
        vectors++; if (free_count !== 4'd15) begin errors++; $display("FAIL t1_free_restore got=%0d exp=15", free_count); end
    endtask

    // Slots 0..2 occupied: slot 3 granted, gate closes on ack, sensor ends it.
    task automatic test_park_sensor();
        cars = 15'h0007;
        step(3);
        vectors++; if (free_count !== 4'd12) begin errors++; $display("FAIL t2_free_init got=%0d exp=12", free_count); end
        entry_req = 1'b1;
        step(1);
        vectors++; if (grant_slot !== 4'd3) begin errors++; $display("FAIL t2_grant_slot got=%0d exp=3", grant_slot); end
        vectors++; if (gate_open !== 1'b1) begin errors++; $display("FAIL t2_gate_open got=%0b exp=1", gate_open); end
        entry_ack = 1'b1;
        step(1);
        entry_ack = 1'b0; entry_req = 1'b0;
        vectors++; if (gate_open !== 1'b0) begin errors++; $display("FAIL t2_gate_closed got=%0b exp=0", gate_open); end
        vectors++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL t2_park_valid got=%0b exp=1", grant_valid); end
        cars = 15'h000F;
        // First sampling edge loads the meta flop, second the synced copy,
        // third is the FSM reacting.
        step(2);
        vectors++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL t2_valid_hold got=%0b exp=1", grant_valid); end
        step(1);
        vectors++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL t2_valid_drop got=%0b exp=0", grant_valid); end
        vectors++; if (free_count !== 4'd11) begin errors++; $display("FAIL t2_free got=%0d exp=11", free_count); end
        step(1);
        vectors++; if (free_count !== 4'd11) begin errors++; $display("FAIL t2_free_settled got=%0d exp=11", free_count); end
    endtask

    // Lot full: no grant, no gate.
    task automatic test_lot_full();
        cars = 15'h7FFF;
        step(3);
        vectors++; if (lot_full !== 1'b1) begin errors++; $display("FAIL t3_lot_full got=%0b exp=1", lot_full); end
        vectors++; if (free_count !== 4'd0) begin errors++; $display("FAIL t3_free got=%0d exp=0", free_count); end
        entry_req = 1'b1;
        step(2);
        vectors++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL t3_grant_valid got=%0b exp=0", grant_valid); end
        vectors++; if (gate_open !== 1'b0) begin errors++; $display("FAIL t3_gate_open got=%0b exp=0", gate_open); end
        entry_req = 1'b0;
        cars = '0;
        step(3);
        vectors++; if (free_count !== 4'd15) begin errors++; $display("FAIL t3_free_empty got=%0d exp=15", free_count); end
        vectors++; if (lot_full !== 1'b0) begin errors++; $display("FAIL t3_not_full got=%0b exp=0", lot_full); end
    endtask

    // Slot 5 granted, ack, no sensor: released after TIMEOUT cycles in PARK.
    task automatic test_timeout();
        cars = 15'h001F;
        step(3);
        vectors++; if (free_count !== 4'd10) begin errors++; $display("FAIL t4_free_init got=%0d exp=10", free_count); end
        entry_req = 1'b1;
        step(1);
        vectors++; if (grant_slot !== 4'd5) begin errors++; $display("FAIL t4_grant_slot got=%0d exp=5", grant_slot); end
        entry_ack = 1'b1;
        step(1);
        entry_ack = 1'b0; entry_req = 1'b0;
        vectors++; if (free_count !== 4'd9) begin errors++; $display("FAIL t4_free_reserved got=%0d exp=9", free_count); end
        // Timer loaded with TIMEOUT-1 at the ack edge reaches 0 after
        // TIMEOUT-1 more edges; the following edge returns to IDLE.
        step(TIMEOUT - 1);
        vectors++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL t4_valid_before got=%0b exp=1", grant_valid); end
        step(1);
        vectors++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL t4_valid_after got=%0b exp=0", grant_valid); end
        step(1);
        vectors++; if (free_count !== 4'd10) begin errors++; $display("FAIL t4_free_restore got=%0d exp=10", free_count); end
    endtask

    // Slot 0 granted, then taken by another car before ack: re-grant slot 1.
    task automatic test_regrant();
        cars = '0;
        step(3);
        vectors++; if (free_count !== 4'd15) begin errors++; $display("FAIL t5_free_init got=%0d exp=15", free_count); end
        entry_req = 1'b1;
        step(1);
        vectors++; if (grant_slot !== 4'd0) begin errors++; $display("FAIL t5_first_slot got=%0d exp=0", grant_slot); end
        cars = 15'h0001;
        step(2);
        vectors++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL t5_still_valid got=%0b exp=1", grant_valid); end
        step(1);
        vectors++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL t5_released got=%0b exp=0", grant_valid); end
        vectors++; if (grant_slot !== 4'd0) begin errors++; $display("FAIL t5_slot_hold got=%0d exp=0", grant_slot); end
        step(1);
        vectors++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL t5_regrant_valid got=%0b exp=1", grant_valid); end
        vectors++; if (grant_slot !== 4'd1) begin errors++; $display("FAIL t5_regrant_slot got=%0d exp=1", grant_slot); end
        vectors++; if (free_count !== 4'd14) begin errors++; $display("FAIL t5_free_between got=%0d exp=14", free_count); end
        step(1);
        vectors++; if (free_count !== 4'd13) begin errors++; $display("FAIL t5_free_regrant got=%0d exp=13", free_count); end
        entry_req = 1'b0;
        step(1);
    endtask

    // Reset mid-GRANT clears outputs without a clock edge.
    task automatic test_mid_reset();
        entry_req = 1'b1;
        step(1);
        vectors++; if (gate_open !== 1'b1) begin errors++; $display("FAIL t6_gate_before got=%0b exp=1", gate_open); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (gate_open !== 1'b0) begin errors++; $display("FAIL t6_gate_async got=%0b exp=0", gate_open); end
        vectors++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL t6_valid_async got=%0b exp=0", grant_valid); end
        vectors++; if (free_count !== 4'd0) begin errors++; $display("FAIL t6_free_async got=%0d exp=0", free_count); end
        entry_req = 1'b0;
        cars = 15'h0003;
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        vectors++; if (free_count !== 4'd13) begin errors++; $display("FAIL t6_free_after got=%0d exp=13", free_count); end
        entry_req = 1'b1;
        step(1);
        vectors++; if (grant_slot !== 4'd2) begin errors++; $display("FAIL t6_grant_slot got=%0d exp=2", grant_slot); end
        vectors++; if (gate_open !== 1'b1) begin errors++; $display("FAIL t6_gate_open got=%0b exp=1", gate_open); end
        entry_req = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_park_sensor();
        test_lot_full();
        test_timeout();
        test_regrant();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
